mixcolumns_iter: RTL and testbench



---
 rtl/aes_gf_pkg.sv | 63 ++++++
 rtl/mixcolumns_iter_if.sv | 25 ++
 rtl/aes_mix_column.sv | 33 +++
 rtl/mixcolumns_iter.sv | 90 +++++++++
 tb/tb_mixcolumns_iter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers and shared types for the AES column-mixing datapath.
// The engine's FSM state type also lives here so checkers can bind to it.
package aes_gf_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [31:0]  aes_col_t;
    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mix_state_e;

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return gf_xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        return gf_xtime(gf_xtime(gf_xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] b);
        return gf_xtime(gf_xtime(gf_xtime(b))) ^ gf_xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] b);
        return gf_xtime(gf_xtime(gf_xtime(b))) ^ gf_xtime(gf_xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] b);
        return gf_xtime(gf_xtime(gf_xtime(b))) ^ gf_xtime(gf_xtime(b)) ^ gf_xtime(b);
    endfunction

    // Column c of a column-major state sits at bits [127-32c -: 32].
    function automatic aes_col_t get_col(input aes_state_t s, input logic [1:0] c);
        case (c)
            2'd0:    return s[127:96];
            2'd1:    return s[95:64];
            2'd2:    return s[63:32];
            default: return s[31:0];
        endcase
    endfunction

    function automatic aes_state_t put_col(input aes_state_t s, input logic [1:0] c,
                                           input aes_col_t v);
        aes_state_t r;
        r = s;
        case (c)
            2'd0:    r[127:96] = v;
            2'd1:    r[95:64]  = v;
            2'd2:    r[63:32]  = v;
            default: r[31:0]   = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mixcolumns_iter_if.sv
// Upstream and downstream handshakes of the iterative MixColumns engine.
// valid/ready: a transfer happens on a rising edge where both are high; a source
// holds valid and its payload stable until that edge, and ready never depends on valid.
interface mixcolumns_iter_if;
    import aes_gf_pkg::*;

    logic       in_valid;
    logic       in_ready;
    logic       in_inv;
    aes_state_t state_in;
    logic       out_valid;
    logic       out_ready;
    aes_state_t state_out;

    modport master (
        output in_valid, in_inv, state_in, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, in_inv, state_in, out_ready,
        output in_ready, out_valid, state_out
    );

endinterface

// File: rtl/aes_mix_column.sv
// Combinational mixer for one 32-bit column: MixColumns when i_inv=0,
// InvMixColumns when i_inv=1. Row 0 is the MSB byte.
module aes_mix_column
    import aes_gf_pkg::*;
(
    input  aes_col_t i_col,
    input  logic     i_inv,
    output aes_col_t o_col
);

    logic [7:0] w_a [4];
    logic [7:0] w_f [4];
    logic [7:0] w_i [4];

    assign w_a[0] = i_col[31:24];
    assign w_a[1] = i_col[23:16];
    assign w_a[2] = i_col[15:8];
    assign w_a[3] = i_col[7:0];

    // Row r uses the coefficient row rotated right by r.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            w_f[r] = gf_xtime(w_a[r]) ^ gf_mul3(w_a[(r + 1) % 4])
                   ^ w_a[(r + 2) % 4] ^ w_a[(r + 3) % 4];
            w_i[r] = gf_mule(w_a[r]) ^ gf_mulb(w_a[(r + 1) % 4])
                   ^ gf_muld(w_a[(r + 2) % 4]) ^ gf_mul9(w_a[(r + 3) % 4]);
        end
    end

    assign o_col = i_inv ? {w_i[0], w_i[1], w_i[2], w_i[3]}
                         : {w_f[0], w_f[1], w_f[2], w_f[3]};

endmodule

// File: rtl/mixcolumns_iter.sv
// Iterative AES MixColumns/InvMixColumns engine: mixes LANES columns per clock
// in place in a working register, then presents the whole state downstream.
module mixcolumns_iter
    import aes_gf_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    mixcolumns_iter_if.slave   bus,
    output logic               busy,
    output mix_state_e         o_dbg_state
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("mixcolumns_iter: LANES must be 1, 2 or 4");
    end

    // With LANES=4 the step wraps to 0 and the only pass starts and ends at column 0.
    localparam logic [1:0] COL_STEP = 2'(LANES);
    localparam logic [1:0] LAST_COL = 2'(4 - LANES);

    mix_state_e r_state, w_next_state;
    logic [1:0] r_col, w_next_col;
    aes_state_t r_work, w_next_work;
    logic       r_inv, w_next_inv;

    aes_col_t   w_lane_out [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_mix_column u_mix (
            .i_col (get_col(r_work, r_col + 2'(l))),
            .i_inv (r_inv),
            .o_col (w_lane_out[l])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_col   <= 2'd0;
            r_work  <= '0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_col   <= w_next_col;
            r_work  <= w_next_work;
            r_inv   <= w_next_inv;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_col   = r_col;
        w_next_work  = r_work;
        w_next_inv   = r_inv;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_next_work  = bus.state_in;
                    w_next_inv   = bus.in_inv;
                    w_next_col   = 2'd0;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    w_next_work = put_col(w_next_work, r_col + 2'(l), w_lane_out[l]);
                end
                w_next_col = r_col + COL_STEP;
                if (r_col == LAST_COL) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.state_out = r_work;
    assign busy          = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mixcolumns_iter.sv
// Bench for mixcolumns_iter with three instances (LANES = 4, 1, 2) checked
// against a matrix-product model over GF(2^8).
module tb_mixcolumns_iter;
    import aes_gf_pkg::mix_state_e;
    import aes_gf_pkg::ST_IDLE;
    import aes_gf_pkg::ST_RUN;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    // unit 0: LANES=4, unit 1: LANES=1, unit 2: LANES=2
    logic         iv [3];
    logic         iinv [3];
    logic         ordy [3];
    logic [127:0] si [3];
    logic         ir [3];
    logic         ov [3];
    logic         bz [3];
    logic [127:0] so [3];
    mix_state_e   dbg [3];

    mixcolumns_iter_if if4 ();
    mixcolumns_iter_if if1 ();
    mixcolumns_iter_if if2 ();

    assign if4.in_valid = iv[0];  assign if4.in_inv = iinv[0];
    assign if4.state_in = si[0];  assign if4.out_ready = ordy[0];
    assign ir[0] = if4.in_ready;  assign ov[0] = if4.out_valid;  assign so[0] = if4.state_out;
    assign if1.in_valid = iv[1];  assign if1.in_inv = iinv[1];
    assign if1.state_in = si[1];  assign if1.out_ready = ordy[1];
    assign ir[1] = if1.in_ready;  assign ov[1] = if1.out_valid;  assign so[1] = if1.state_out;
    assign if2.in_valid = iv[2];  assign if2.in_inv = iinv[2];
    assign if2.state_in = si[2];  assign if2.out_ready = ordy[2];
    assign ir[2] = if2.in_ready;  assign ov[2] = if2.out_valid;  assign so[2] = if2.state_out;

    mixcolumns_iter #(.LANES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4), .busy(bz[0]), .o_dbg_state(dbg[0]));
    mixcolumns_iter #(.LANES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1), .busy(bz[1]), .o_dbg_state(dbg[1]));
    mixcolumns_iter #(.LANES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2), .busy(bz[2]), .o_dbg_state(dbg[2]));

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic       hi;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            hi = x[7];
            x = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1B;
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic inv);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gf_mul_ref(coef[(k - row + 4) % 4], s[127 - 32*c - 8*k -: 8]);
                end
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int lanes_of(input int u);
        return (u == 0) ? 4 : (u == 1) ? 1 : 2;
    endfunction

    // Issue one state, wait for the result, then pop it. lat counts edges
    // from acceptance until out_valid is seen.
    task automatic run_one(input int u, input logic inv, input logic [127:0] s,
                           output logic [127:0] res, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!ir[u] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (ir[u] !== 1'b1) begin
            failures++;
            $display("FAIL ready_wait unit=%0d in_ready=%b required=1", u, ir[u]);
        end
        iv[u] = 1'b1; iinv[u] = inv; si[u] = s;
        @(negedge clk);
        iv[u] = 1'b0; iinv[u] = 1'($urandom()); si[u] = rand128();
        lat = 0;
        while (!ov[u] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        res = so[u];
        ordy[u] = 1'b1;
        @(negedge clk);
        ordy[u] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (ir[u] !== 1'b1 || ov[u] !== 1'b0 || bz[u] !== 1'b0 || so[u] !== 128'h0) begin
                failures++;
                $display("FAIL reset_hold unit=%0d ir=%b ov=%b busy=%b out=%h required 1/0/0/0",
                         u, ir[u], ov[u], bz[u], so[u]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (ir[u] !== 1'b1 || ov[u] !== 1'b0 || bz[u] !== 1'b0 || dbg[u] !== ST_IDLE) begin
                failures++;
                $display("FAIL reset_release unit=%0d ir=%b ov=%b busy=%b state=%0d",
                         u, ir[u], ov[u], bz[u], dbg[u]);
            end
        end
    endtask

    task automatic test_known(input int u, input logic inv, input logic [127:0] s,
                              input logic [127:0] exp, input int exp_lat);
        logic [127:0] res;
        int           lat;
        run_one(u, inv, s, res, lat);
        checks++;
        if (res !== exp) begin
            failures++;
            $display("FAIL known_vector unit=%0d got=%h required=%h", u, res, exp);
        end
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL known_latency unit=%0d got=%0d required=%0d", u, lat, exp_lat);
        end
    endtask

    task automatic test_random(input int u, input int n);
        logic [127:0] s, res;
        logic         inv;
        int           lat;
        for (int i = 0; i < n; i++) begin
            s = rand128();
            inv = 1'($urandom());
            run_one(u, inv, s, res, lat);
            checks++;
            if (res !== mix_ref(s, inv) || lat !== 4 / lanes_of(u)) begin
                failures++;
                $display("FAIL random unit=%0d inv=%b got=%h required=%h lat=%0d",
                         u, inv, res, mix_ref(s, inv), lat);
            end
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] s, fwd, back;
        int           lat_f, lat_b;
        for (int i = 0; i < 200; i++) begin
            s = rand128();
            if (i == 0) s[127:64] = 64'hdb135345_c6c6c6c6;
            run_one(2, 1'b0, s, fwd, lat_f);
            run_one(2, 1'b1, fwd, back, lat_b);
            checks++;
            if (fwd !== mix_ref(s, 1'b0)) begin
                failures++;
                $display("FAIL rt_forward i=%0d got=%h required=%h", i, fwd, mix_ref(s, 1'b0));
            end
            checks++;
            if (back !== s) begin
                failures++;
                $display("FAIL rt_inverse i=%0d got=%h required=%h", i, back, s);
            end
            checks++;
            if (lat_f !== 2 || lat_b !== 2) begin
                failures++;
                $display("FAIL rt_latency i=%0d got=%0d/%0d required=2", i, lat_f, lat_b);
            end
            if (i == 0) begin
                checks++;
                if (fwd[127:64] !== 64'h8e4da1bc_c6c6c6c6) begin
                    failures++;
                    $display("FAIL rt_columns got=%h required=8e4da1bcc6c6c6c6", fwd[127:64]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] s, s2, exp, exp2;
        logic         inv2;
        int           lat;
        s = rand128(); exp = mix_ref(s, 1'b0);
        s2 = rand128(); inv2 = 1'($urandom()); exp2 = mix_ref(s2, inv2);
        @(negedge clk);
        iv[0] = 1'b1; iinv[0] = 1'b0; si[0] = s;
        @(negedge clk);
        iv[0] = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        iv[0] = 1'b1; iinv[0] = inv2; si[0] = s2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (so[0] !== exp || ir[0] !== 1'b0 || ov[0] !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d out=%h required=%h ir=%b ov=%b", i, so[0], exp, ir[0], ov[0]);
            end
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        ordy[0] = 1'b0;
        checks++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_release ir=%b ov=%b required 1/0", ir[0], ov[0]);
        end
        @(negedge clk);
        iv[0] = 1'b0;
        checks++;
        if (ir[0] !== 1'b0 || bz[0] !== 1'b1) begin
            failures++;
            $display("FAIL bp_accept ir=%b busy=%b required 0/1", ir[0], bz[0]);
        end
        lat = 0;
        while (!ov[0] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (so[0] !== exp2) begin
            failures++;
            $display("FAIL bp_second got=%h required=%h", so[0], exp2);
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        ordy[0] = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] s, res;
        logic         inv;
        int           lat;
        @(negedge clk);
        iv[1] = 1'b1; iinv[1] = 1'b0; si[1] = rand128();
        @(negedge clk);
        iv[1] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dbg[1] !== ST_RUN || ov[1] !== 1'b0) begin
            failures++;
            $display("FAIL midrun_state state=%0d ov=%b required RUN/0", dbg[1], ov[1]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (so[1] !== 128'h0 || ov[1] !== 1'b0 || bz[1] !== 1'b0 || ir[1] !== 1'b1) begin
            failures++;
            $display("FAIL midrun_reset out=%h ov=%b busy=%b ir=%b required 0/0/0/1", so[1], ov[1], bz[1], ir[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        s = rand128();
        inv = 1'($urandom());
        run_one(1, inv, s, res, lat);
        checks++;
        if (res !== mix_ref(s, inv) || lat !== 4) begin
            failures++;
            $display("FAIL midrun_next got=%h required=%h lat=%0d", res, mix_ref(s, inv), lat);
        end
    endtask

    task automatic test_back_to_back(input int u);
        logic [127:0] exp_q [$];
        int           acc_cyc [$];
        logic [127:0] d, exp;
        logic         inv;
        int           sent, got, guard;
        sent = 0; got = 0; guard = 0;
        ordy[u] = 1'b1;
        @(negedge clk);
        while (got < 8 && guard < 300) begin
            if (ov[u]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra unit=%0d out=%h required none", u, so[u]);
                end else begin
                    exp = exp_q.pop_front();
                    if (so[u] !== exp) begin
                        failures++;
                        $display("FAIL b2b_data unit=%0d got=%h required=%h", u, so[u], exp);
                    end
                end
                got++;
            end
            if (ir[u] && sent < 8) begin
                d = rand128(); inv = 1'($urandom());
                iv[u] = 1'b1; iinv[u] = inv; si[u] = d;
                exp_q.push_back(mix_ref(d, inv));
                acc_cyc.push_back(cyc);
                sent++;
            end else begin
                iv[u] = (sent < 8); iinv[u] = 1'($urandom()); si[u] = rand128();
            end
            @(negedge clk);
            guard++;
        end
        iv[u] = 1'b0;
        ordy[u] = 1'b0;
        checks++;
        if (got !== 8) begin
            failures++;
            $display("FAIL b2b_count unit=%0d got=%0d required=8", u, got);
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 4 / lanes_of(u) + 2) begin
                failures++;
                $display("FAIL b2b_interval unit=%0d i=%0d got=%0d required=%0d",
                         u, i, acc_cyc[i] - acc_cyc[i-1], 4 / lanes_of(u) + 2);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            iv[u] = 1'b0; iinv[u] = 1'b0; ordy[u] = 1'b0; si[u] = '0;
        end
        repeat (2) @(negedge clk);
        test_reset();
        test_known(0, 1'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5,
                   128'h046681e5e0cb199a48f8d37a2806264c, 1);
        test_known(1, 1'b1, 128'h046681e5e0cb199a48f8d37a2806264c,
                   128'hd4bf5d30e0b452aeb84111f11e2798e5, 4);
        test_random(0, 6);
        test_random(1, 6);
        test_round_trip();
        test_backpressure();
        test_reset_mid_run();
        for (int u = 0; u < 3; u++) test_back_to_back(u);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog cyc=%0d required completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
